// File: rtl/synth_pkg.sv
// synth_pkg: shared constants, mix FSM state type and the key-to-phase-increment
// function used to build the key_phase_rom contents.
//   NUM_KEYS    : highest valid piano key number (keys 1..NUM_KEYS sound)
//   SILENCE_KEY : key number that produces no tone
//   MID         : offset-binary zero level of the 8-bit output
//   key_inc()   : per-sample phase increment for a key
package synth_pkg;

    localparam int NUM_KEYS    = 88;
    localparam int SILENCE_KEY = 0;
    localparam int MID         = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACC,
        ST_OUT
    } mix_state_e;

    // Equal-tempered pitch with A4 (key 49) at 440 Hz, converted to an
    // accumulator step per sample period; the cast to longint rounds to nearest.
    function automatic longint key_inc(input int key, input int acc_w,
                                       input int sample_div, input real clk_hz);
        real f;
        if (key <= SILENCE_KEY || key > NUM_KEYS) begin
            key_inc = 0;
        end else begin
            f = 440.0 * (2.0 ** ((key - 49) / 12.0)) * (2.0 ** acc_w)
                * sample_div / clk_hz;
            key_inc = longint'(f);
        end
    endfunction

endpackage

// File: rtl/key_phase_rom.sv
// key_phase_rom: combinational key number -> phase increment lookup.
//   key : piano key number; 0 or above NUM_KEYS is silent
//   inc : accumulator increment per sample period (0 for silent keys)
module key_phase_rom
    import synth_pkg::*;
#(
    parameter int KEY_W      = 7,
    parameter int ACC_W      = 24,
    parameter int SAMPLE_DIV = 1024,
    parameter int CLK_HZ     = 50_000_000
) (
    input  logic [KEY_W-1:0] key,
    output logic [ACC_W-1:0] inc
);

    logic [ACC_W-1:0] table_w [NUM_KEYS+1];

    for (genvar k = 0; k <= NUM_KEYS; k++) begin : g_entry
        localparam longint INC = key_inc(k, ACC_W, SAMPLE_DIV, real'(CLK_HZ));
        assign table_w[k] = INC[ACC_W-1:0];
    end

    always_comb begin
        inc = '0;
        if (int'(key) <= NUM_KEYS) begin
            inc = table_w[key];
        end
    end

endmodule

// File: rtl/sine_wave_mem.sv
// sine_wave_mem: one full sine period, 8-bit offset binary, registered read.
//   clk  : system clock
//   addr : phase address (0..2^ADDR_W-1 covers one period)
//   out  : round(128 + 127*sin(2*pi*addr/2^ADDR_W)), one cycle after addr
module sine_wave_mem #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        out
);

    localparam real PI    = 3.14159265358979323846;
    localparam int  DEPTH = 2 ** ADDR_W;

    logic [7:0] rom_w [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam int SAMPLE = int'(128.0 + 127.0 * $sin(2.0 * PI * i / DEPTH));
        assign rom_w[i] = SAMPLE[7:0];
    end

    always_ff @(posedge clk) begin
        out <= rom_w[addr];
    end

endmodule

// File: rtl/poly_note_synth.sv
// poly_note_synth: VOICES-voice note synthesiser sharing one sine ROM.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   note      : key number per voice, voice v at [v*KEY_W +: KEY_W]
//   gate      : per-voice gate, 1 = attack/hold, 0 = release
//   out       : mixed 8-bit offset-binary sample (128 = zero), held between frames
//   out_valid : one-cycle pulse while a new out is presented
//   busy      : high while the mix FSM walks the voices
module poly_note_synth
    import synth_pkg::*;
#(
    parameter int VOICES       = 4,
    parameter int KEY_W        = 7,
    parameter int ACC_W        = 24,
    parameter int ADDR_W       = 12,
    parameter int SAMPLE_DIV   = 1024,
    parameter int ATTACK_STEP  = 4,
    parameter int RELEASE_STEP = 2,
    parameter int CLK_HZ       = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VOICES*KEY_W-1:0]   note,
    input  logic [VOICES-1:0]         gate,
    output logic [7:0]                out,
    output logic                      out_valid,
    output logic                      busy
);

    localparam int LOGV   = $clog2(VOICES);
    localparam int SUM_W  = 9 + LOGV;
    localparam int CNT_W  = $clog2(SAMPLE_DIV);
    localparam int VIDX_W = (LOGV > 0) ? LOGV : 1;

    if (SAMPLE_DIV < 3 * VOICES + 4) begin : g_bad_div
        $error("poly_note_synth: SAMPLE_DIV=%0d too small for VOICES=%0d", SAMPLE_DIV, VOICES);
    end
    if (VOICES < 1 || VOICES > 8 || (1 << LOGV) != VOICES) begin : g_bad_voices
        $error("poly_note_synth: VOICES=%0d must be a power of 2 in 1..8", VOICES);
    end

    // Sample-period divider
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick;

    assign tick  = (div_q == CNT_W'(SAMPLE_DIV - 1));
    assign div_d = tick ? '0 : div_q + CNT_W'(1);

    // Per-voice phase accumulators and envelopes
    logic [ACC_W-1:0] acc_q [VOICES];
    logic [ACC_W-1:0] acc_d [VOICES];
    logic [ACC_W-1:0] inc_w [VOICES];
    logic [7:0]       env_q [VOICES];
    logic [7:0]       env_d [VOICES];

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        key_phase_rom #(
            .KEY_W      (KEY_W),
            .ACC_W      (ACC_W),
            .SAMPLE_DIV (SAMPLE_DIV),
            .CLK_HZ     (CLK_HZ)
        ) u_key_rom (
            .key (note[v*KEY_W +: KEY_W]),
            .inc (inc_w[v])
        );
    end

    always_comb begin
        for (int unsigned v = 0; v < VOICES; v++) begin
            acc_d[v] = acc_q[v];
            env_d[v] = env_q[v];
            if (tick) begin
                acc_d[v] = acc_q[v] + inc_w[v];
                if (gate[v]) begin
                    env_d[v] = (env_q[v] > 8'(255 - ATTACK_STEP)) ? 8'd255
                                                                  : env_q[v] + 8'(ATTACK_STEP);
                end else begin
                    env_d[v] = (env_q[v] < 8'(RELEASE_STEP)) ? 8'd0
                                                             : env_q[v] - 8'(RELEASE_STEP);
                end
            end
        end
    end

    // Mix datapath
    mix_state_e              state_q, state_d;
    logic [VIDX_W-1:0]       vox_q, vox_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [7:0]              out_q, out_d;

    logic [ADDR_W-1:0]       rom_addr;
    logic [7:0]              rom_out;
    logic signed [8:0]       s_w;
    logic signed [17:0]      prod_w;
    logic signed [8:0]       p_w;
    logic signed [SUM_W-1:0] sum_next_w;
    logic signed [SUM_W-1:0] mix_w;
    logic signed [SUM_W:0]   biased_w;
    logic [7:0]              clamped_w;

    sine_wave_mem #(
        .ADDR_W (ADDR_W)
    ) u_sine (
        .clk  (clk),
        .addr (rom_addr),
        .out  (rom_out)
    );

    // Address is held for the whole ISSUE/WAIT/ACC triple of a voice, so the
    // ROM word read in ACC belongs to that voice.
    assign rom_addr   = acc_q[vox_q][ACC_W-1 -: ADDR_W];
    assign s_w        = signed'({1'b0, rom_out}) - 9'sd128;
    assign prod_w     = s_w * signed'({1'b0, env_q[vox_q]});
    assign p_w        = 9'(prod_w >>> 8);
    assign sum_next_w = sum_q + SUM_W'(p_w);
    assign mix_w      = sum_next_w >>> LOGV;
    assign biased_w   = (SUM_W+1)'(mix_w) + (SUM_W+1)'(MID);

    always_comb begin
        clamped_w = biased_w[7:0];
        if (biased_w < 0) begin
            clamped_w = 8'd0;
        end else if (biased_w > 255) begin
            clamped_w = 8'd255;
        end
    end

    // The final sample is registered on the last ACC cycle so that out and
    // out_valid are both presented during the OUT state.
    always_comb begin
        state_d = state_q;
        vox_d   = vox_q;
        sum_d   = sum_q;
        out_d   = out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_ISSUE;
                    vox_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_ACC;
            ST_ACC: begin
                sum_d = sum_next_w;
                if (vox_q == VIDX_W'(VOICES - 1)) begin
                    state_d = ST_OUT;
                    out_d   = clamped_w;
                end else begin
                    vox_d   = vox_q + VIDX_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_OUT:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            state_q <= ST_IDLE;
            vox_q   <= '0;
            sum_q   <= '0;
            out_q   <= 8'(MID);
            for (int unsigned v = 0; v < VOICES; v++) begin
                acc_q[v] <= '0;
                env_q[v] <= '0;
            end
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            vox_q   <= vox_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            for (int unsigned v = 0; v < VOICES; v++) begin
                acc_q[v] <= acc_d[v];
                env_q[v] <= env_d[v];
            end
        end
    end

    assign out       = out_q;
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_poly_note_synth.sv
// tb_poly_note_synth: randomized/directed stimulus with a scoreboard. A reference
// model computes each frame's sample from the pitch/envelope rules on every
// sample tick and queues it with its due cycle; a monitor on the falling edge
// compares out, out_valid and busy against the queue head.
module tb_poly_note_synth;

    localparam int V      = 4;
    localparam int KW     = 7;
    localparam int AW     = 24;
    localparam int ADW    = 12;
    localparam int DIV    = 32;
    localparam int ATK    = 4;
    localparam int REL    = 2;
    localparam int CLK_HZ = 1_000_000;
    localparam real PI    = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst;
    logic [V*KW-1:0]   note;
    logic [V-1:0]      gate;
    logic [7:0]        out;
    logic              out_valid;
    logic              busy;

    poly_note_synth #(
        .VOICES       (V),
        .KEY_W        (KW),
        .ACC_W        (AW),
        .ADDR_W       (ADW),
        .SAMPLE_DIV   (DIV),
        .ATTACK_STEP  (ATK),
        .RELEASE_STEP (REL),
        .CLK_HZ       (CLK_HZ)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note      (note),
        .gate      (gate),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference tables straight from the pitch and sine definitions
    int     sine_tbl [4096];
    longint inc_tbl  [89];

    initial begin
        real f;
        for (int i = 0; i < 4096; i++) begin
            sine_tbl[i] = int'(128.0 + 127.0 * $sin(2.0 * PI * real'(i) / 4096.0));
        end
        inc_tbl[0] = 0;
        for (int k = 1; k <= 88; k++) begin
            f = 440.0 * (2.0 ** ((k - 49) / 12.0)) * (2.0 ** AW) * DIV / real'(CLK_HZ);
            inc_tbl[k] = longint'(f);
        end
    end

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    typedef struct {
        int     val;
        longint due;
    } exp_t;

    exp_t             exp_q[$];
    longint unsigned  m_acc [V];
    int               m_env [V];
    int               m_div;
    longint           cycle_no;
    int               last_out;

    task automatic model_tick();
        int  key, sum, s, o, a;
        exp_t e;
        for (int v = 0; v < V; v++) begin
            key = int'(note[v*KW +: KW]);
            if (key >= 1 && key <= 88) m_acc[v] = (m_acc[v] + inc_tbl[key]) % (64'd1 << AW);
            if (gate[v]) m_env[v] = (m_env[v] + ATK > 255) ? 255 : m_env[v] + ATK;
            else         m_env[v] = (m_env[v] - REL < 0)   ? 0   : m_env[v] - REL;
        end
        sum = 0;
        for (int v = 0; v < V; v++) begin
            a   = int'(m_acc[v] / (64'd1 << (AW - ADW)));
            s   = sine_tbl[a] - 128;
            sum = sum + fdiv(s * m_env[v], 256);
        end
        o = fdiv(sum, V) + 128;
        if (o < 0)   o = 0;
        if (o > 255) o = 255;
        e.val = o;
        e.due = cycle_no + 3 * V;
        exp_q.push_back(e);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div    = 0;
            cycle_no = 0;
            last_out = 128;
            exp_q.delete();
            for (int v = 0; v < V; v++) begin
                m_acc[v] = 0;
                m_env[v] = 0;
            end
        end else begin
            cycle_no++;
            if (m_div == DIV - 1) begin
                m_div = 0;
                model_tick();
            end else begin
                m_div++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   due_now;
        bit   exp_busy;
        if (!rst) begin
            due_now  = (exp_q.size() > 0) && (cycle_no == exp_q[0].due);
            exp_busy = (exp_q.size() > 0) && (cycle_no >= exp_q[0].due - 3 * V)
                       && (cycle_no <= exp_q[0].due);
            check("busy", busy, exp_busy);
            check("out_valid", out_valid, due_now);
            if (due_now) begin
                e = exp_q.pop_front();
                check("sample", out, e.val);
                last_out = e.val;
            end else begin
                check("out_hold", out, last_out);
                if (exp_q.size() > 0 && cycle_no > exp_q[0].due) begin
                    check("frame_overdue", cycle_no, exp_q[0].due);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_voice(input int v, input int key, input bit g);
        note[v*KW +: KW] = KW'(key);
        gate[v]          = g;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * DIV) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst  = 1'b1;
        note = '0;
        gate = '0;
        repeat (3) @(negedge clk);
        check("reset_out", out, 128);
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // All voices silent but gated: output must stay at mid-scale
        gate = '1;
        wait_ticks(10);

        // Single A4 voice: attack to full scale
        gate = '0;
        set_voice(0, 49, 1'b1);
        wait_ticks(70);

        // Release to silence
        set_voice(0, 49, 1'b0);
        wait_ticks(132);

        // Two identical top-key voices, then a jump to the lowest key
        set_voice(0, 88, 1'b1);
        set_voice(1, 88, 1'b1);
        wait_ticks(70);
        set_voice(0, 1, 1'b1);
        set_voice(1, 1, 1'b1);
        wait_ticks(8);

        // Note change while busy takes effect only at the next tick
        n = 0;
        while (!busy && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen", busy, 1);
        set_voice(2, 70, 1'b1);
        wait_ticks(6);

        // Randomized notes/gates, changed at arbitrary points in the frame
        for (int c = 0; c < 100 * DIV; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                set_voice(int'($urandom_range(0, V - 1)), int'($urandom_range(0, 100)),
                          $urandom_range(0, 1) == 1);
            end
        end

        // Reset in the middle of a frame
        n = 0;
        @(negedge clk);
        while (!(busy && !out_valid) && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("midframe_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midreset_out", out, 128);
        check("midreset_valid", out_valid, 0);
        check("midreset_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!out_valid && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("first_valid_after_reset", n, DIV + 3 * V);
        wait_ticks(5);

        // Drain outstanding frames
        n = 0;
        while (exp_q.size() > 0 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
